// File: rtl/qbus_pkg.sv
// Shared types and default timing for the Q-bus DMA master.
package qbus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      SACK,
      ADDR,
      SYNC,
      WAIT,
      END
   } qbus_state_t;

   localparam int ADDR_SETUP_DEF  = 3;
   localparam int DATA_SETUP_DEF  = 2;
   localparam int NXM_TIMEOUT_DEF = 200;
   localparam int READ_LATCH_DEF  = 4;
   localparam int BURST_LIMIT     = 4;
   localparam int BURST_W         = $clog2(BURST_LIMIT);
   localparam int CNT_W           = 8;

endpackage

// File: rtl/qbus_sync.sv
// Two-flop synchronizer bank for asynchronous Q-bus receiver lines.
module qbus_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             init,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (init) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/qbus_dma_master.sv
// Q-bus DMA mastership and DATI/DATO cycle engine for the RK controller.
// Define QBUS_DMA_BURST_EN to allow up to BURST_LIMIT transfers per grant.
module qbus_dma_master
   import qbus_pkg::*;
#(
   parameter int ADDR_SETUP  = ADDR_SETUP_DEF,
   parameter int DATA_SETUP  = DATA_SETUP_DEF,
   parameter int NXM_TIMEOUT = NXM_TIMEOUT_DEF,
   parameter int READ_LATCH  = READ_LATCH_DEF
) (
   input  logic clk,
   input  logic init,
   input  logic dma_read_req,
   input  logic dma_write_req,
   output logic dma_bus_master,
   output logic dma_complete,
   output logic dma_nxm,
   output logic addr_drive,
   output logic data_drive,
   output logic TDMR,
   input  logic RDMG,
   output logic TDMGO,
   output logic TSACK,
   input  logic RSYNC,
   input  logic RRPLY,
   output logic TSYNC,
   output logic TDIN,
   output logic TDOUT
);

   logic [2:0]       sync_q;
   logic             rdmg_s, rsync_s, rrply_s;
   logic             req_any, burst_more, end_done;
   qbus_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             is_write;
   logic             rd_latch;

   qbus_sync #(.WIDTH(3)) u_sync (
      .clk  (clk),
      .init (init),
      .d    ({RDMG, RSYNC, RRPLY}),
      .q    (sync_q)
   );

   assign rdmg_s   = sync_q[2];
   assign rsync_s  = sync_q[1];
   assign rrply_s  = sync_q[0];
   assign req_any  = dma_read_req | dma_write_req;
   // A timed-out slave may never drop RPLY, so an NXM leaves END at once.
   assign end_done = (state == END) && (!rrply_s || dma_nxm);

`ifdef QBUS_DMA_BURST_EN
   logic [BURST_W-1:0] xfer_cnt;

   assign burst_more = !dma_nxm && (is_write ? dma_write_req : dma_read_req) &&
                       (xfer_cnt != BURST_W'(BURST_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (init) begin
         xfer_cnt <= '0;
      end else if (state == SACK) begin
         xfer_cnt <= '0;
      end else if (end_done && burst_more) begin
         xfer_cnt <= xfer_cnt + BURST_W'(1);
      end
   end
`else
   assign burst_more = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (init) begin
         state          <= IDLE;
         cnt            <= '0;
         is_write       <= 1'b0;
         rd_latch       <= 1'b0;
         dma_bus_master <= 1'b0;
         dma_complete   <= 1'b0;
         dma_nxm        <= 1'b0;
         addr_drive     <= 1'b0;
         data_drive     <= 1'b0;
         TDMR           <= 1'b0;
         TDMGO          <= 1'b0;
         TSACK          <= 1'b0;
         TSYNC          <= 1'b0;
         TDIN           <= 1'b0;
         TDOUT          <= 1'b0;
      end else begin
         dma_complete <= 1'b0;
         dma_nxm      <= 1'b0;
         case (state)
            IDLE: begin
               // Once passing a grant downstream, keep passing it until it drops.
               if (rdmg_s && (TDMGO || !req_any)) begin
                  TDMGO <= 1'b1;
               end else begin
                  TDMGO <= 1'b0;
                  if (req_any) begin
                     TDMR     <= 1'b1;
                     is_write <= dma_write_req;
                     state    <= REQ;
                  end
               end
            end
            REQ: begin
               if (!req_any) begin
                  TDMR  <= 1'b0;
                  state <= IDLE;
               end else if (rdmg_s && !rsync_s && !rrply_s) begin
                  TDMR           <= 1'b0;
                  TSACK          <= 1'b1;
                  dma_bus_master <= 1'b1;
                  state          <= SACK;
               end
            end
            SACK: begin
               if (!rdmg_s) begin
                  addr_drive <= 1'b1;
                  data_drive <= is_write;
                  cnt        <= '0;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               if (cnt == CNT_W'(ADDR_SETUP - 1)) begin
                  TSYNC <= 1'b1;
                  cnt   <= '0;
                  state <= SYNC;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SYNC: begin
               addr_drive <= 1'b0;
               rd_latch   <= 1'b0;
               if (!is_write) begin
                  TDIN  <= 1'b1;
                  cnt   <= '0;
                  state <= WAIT;
               end else if (cnt == CNT_W'(DATA_SETUP - 1)) begin
                  TDOUT <= 1'b1;
                  cnt   <= '0;
                  state <= WAIT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT: begin
               // After a DATI reply, cnt is reused to deskew read data.
               if (rd_latch) begin
                  if (cnt == CNT_W'(READ_LATCH - 1)) begin
                     dma_complete <= 1'b1;
                     TDIN         <= 1'b0;
                     state        <= END;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end else if (rrply_s) begin
                  if (is_write) begin
                     dma_complete <= 1'b1;
                     TDOUT        <= 1'b0;
                     data_drive   <= 1'b0;
                     state        <= END;
                  end else begin
                     rd_latch <= 1'b1;
                     cnt      <= CNT_W'(1);
                  end
               end else if (cnt == CNT_W'(NXM_TIMEOUT - 1)) begin
                  dma_nxm    <= 1'b1;
                  TDIN       <= 1'b0;
                  TDOUT      <= 1'b0;
                  data_drive <= 1'b0;
                  state      <= END;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            END: begin
               if (end_done) begin
                  TSYNC <= 1'b0;
                  if (burst_more) begin
                     addr_drive <= 1'b1;
                     data_drive <= is_write;
                     cnt        <= '0;
                     state      <= ADDR;
                  end else begin
                     TSACK          <= 1'b0;
                     dma_bus_master <= 1'b0;
                     state          <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qbus_dma_master.sv
// Self-checking bench for qbus_dma_master: bench plays arbiter and slave.
module tb_qbus_dma_master;

   localparam int ADDR_SETUP  = 3;
   localparam int DATA_SETUP  = 2;
   localparam int NXM_TIMEOUT = 200;
   localparam int READ_LATCH  = 4;
   localparam int SYNC_LAT    = 2;

   localparam int S_DMR = 0, S_SACK = 1, S_ADDR = 2, S_SYNC = 3, S_DIN = 4;
   localparam int S_DOUT = 5, S_CMP = 6, S_NXM = 7, S_MASTER = 8, S_DMGO = 9;

`ifdef QBUS_DMA_BURST_EN
   localparam int EXP_PERIODS = 2;
   int exp_per [6] = '{4, 2, 0, 0, 0, 0};
`else
   localparam int EXP_PERIODS = 6;
   int exp_per [6] = '{1, 1, 1, 1, 1, 1};
`endif

   logic clk = 1'b0;
   logic init, dma_read_req, dma_write_req, RDMG, RSYNC, RRPLY;
   logic dma_bus_master, dma_complete, dma_nxm, addr_drive, data_drive;
   logic TDMR, TDMGO, TSACK, TSYNC, TDIN, TDOUT;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_done = 0;
   int n_nxm = 0;
   logic init_q = 1'b0;
   logic prev_cmp = 1'b0;
   logic prev_nxm = 1'b0;
   bit exp_write = 1'b0;
   bit check_en = 1'b0;

   qbus_dma_master dut (
      .clk            (clk),
      .init           (init),
      .dma_read_req   (dma_read_req),
      .dma_write_req  (dma_write_req),
      .dma_bus_master (dma_bus_master),
      .dma_complete   (dma_complete),
      .dma_nxm        (dma_nxm),
      .addr_drive     (addr_drive),
      .data_drive     (data_drive),
      .TDMR           (TDMR),
      .RDMG           (RDMG),
      .TDMGO          (TDMGO),
      .TSACK          (TSACK),
      .RSYNC          (RSYNC),
      .RRPLY          (RRPLY),
      .TSYNC          (TSYNC),
      .TDIN           (TDIN),
      .TDOUT          (TDOUT)
   );

   always #25 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      init_q <= init;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         S_DMR:    return TDMR;
         S_SACK:   return TSACK;
         S_ADDR:   return addr_drive;
         S_SYNC:   return TSYNC;
         S_DIN:    return TDIN;
         S_DOUT:   return TDOUT;
         S_CMP:    return dma_complete;
         S_NXM:    return dma_nxm;
         S_MASTER: return dma_bus_master;
         S_DMGO:   return TDMGO;
         default:  return 1'b0;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitSig(input int sel, input logic lvl, input int budget, input string name, output int t);
      int n;
      n = 0;
      while (sig(sel) !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      if (sig(sel) !== lvl) checkOutput({name, "_timeout"}, 32'(sig(sel)), 32'(lvl));
   endtask

   // Bus-protocol rules that hold on every cycle, whatever the transfer.
   always @(negedge clk) begin
      if (init_q) begin
         checkOutput("reset_outputs", {dma_bus_master, dma_complete, dma_nxm, addr_drive, data_drive,
                                       TDMR, TDMGO, TSACK, TSYNC, TDIN, TDOUT}, 0);
      end else if (check_en) begin
         checkOutput("complete_nxm_exclusive", 32'(dma_complete & dma_nxm), 0);
         checkOutput("complete_width", 32'(dma_complete & prev_cmp), 0);
         checkOutput("nxm_width", 32'(dma_nxm & prev_nxm), 0);
         checkOutput("data_drive_dir", 32'(data_drive & ~(exp_write & dma_bus_master)), 0);
         checkOutput("tdin_dir", 32'(TDIN & exp_write), 0);
         checkOutput("tdout_dir", 32'(TDOUT & ~exp_write), 0);
         checkOutput("sack_is_master", 32'(TSACK), 32'(dma_bus_master));
         checkOutput("sync_needs_master", 32'(TSYNC & ~dma_bus_master), 0);
         checkOutput("dmr_sack_exclusive", 32'(TDMR & TSACK), 0);
      end
      if (dma_complete === 1'b1) n_done++;
      if (dma_nxm === 1'b1) n_nxm++;
      prev_cmp = dma_complete;
      prev_nxm = dma_nxm;
   end

   task automatic applyStimulus(input bit wr, input int gdly, input int rdly, input bit nxm_case, output int lat);
      int t, ta, ts, tst, tr, tc, tn, td, c0;
      exp_write = wr;
      lat = -1;
      if (wr) dma_write_req = 1'b1;
      else    dma_read_req  = 1'b1;
      waitSig(S_DMR, 1'b1, 10, "dmr_rise", t);
      tick(gdly);
      RDMG = 1'b1;
      waitSig(S_SACK, 1'b1, 10, "sack_rise", t);
      checkOutput("dmr_off_at_sack", 32'(TDMR), 0);
      RDMG = 1'b0;
      waitSig(S_ADDR, 1'b1, 10, "addr_rise", ta);
      checkOutput("data_drive_at_addr", 32'(data_drive), 32'(wr));
      waitSig(S_SYNC, 1'b1, 10, "tsync_rise", ts);
      checkOutput("addr_to_sync", ts - ta, ADDR_SETUP);
      checkOutput("addr_held_with_sync", 32'(addr_drive), 1);
      tick(1);
      checkOutput("addr_released", 32'(addr_drive), 0);
      if (!wr) begin
         checkOutput("tdin_after_sync", 32'(TDIN), 1);
         tst = cyc;
      end else begin
         waitSig(S_DOUT, 1'b1, 10, "tdout_rise", tst);
         checkOutput("sync_to_tdout", tst - ts, DATA_SETUP);
      end
      if (nxm_case) begin
         c0 = n_done;
         waitSig(S_NXM, 1'b1, NXM_TIMEOUT + 20, "nxm_rise", tn);
         lat = tn - tst;
         checkOutput("nxm_strobes_off", {TDIN, TDOUT, data_drive}, 0);
         tick(1);
         checkOutput("nxm_release", {TSYNC, TDIN, TDOUT, TSACK, dma_bus_master, addr_drive, data_drive, dma_nxm}, 0);
         checkOutput("no_complete_on_nxm", n_done - c0, 0);
         dma_write_req = 1'b0;
         dma_read_req  = 1'b0;
      end else begin
         tick(rdly);
         RRPLY = 1'b1;
         tr = cyc;
         waitSig(S_CMP, 1'b1, 20, "complete_rise", tc);
         lat = tc - tr;
         checkOutput("rply_to_complete", lat, SYNC_LAT + (wr ? 1 : READ_LATCH));
         checkOutput("strobes_off_at_complete", {TDIN, TDOUT, data_drive}, 0);
         checkOutput("sync_held_at_complete", 32'(TSYNC), 1);
         dma_write_req = 1'b0;
         dma_read_req  = 1'b0;
         RRPLY = 1'b0;
         td = cyc;
         waitSig(S_MASTER, 1'b0, 10, "release", t);
         checkOutput("rply_drop_to_release", t - td, SYNC_LAT + 1);
         checkOutput("sync_sack_off_at_release", {TSYNC, TSACK}, 0);
      end
      tick(1);
      checkOutput("idle_after_transfer", {dma_bus_master, addr_drive, data_drive, TDMR, TSACK, TSYNC, TDIN, TDOUT}, 0);
   endtask

   initial begin
      #(50 * 20000);
      $display("[TB] FAIL watchdog: got no finish, expected finish within 20000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat, t, t2, c0, n0, words, periods, cur;
      int per [8];
      logic prev_m;
      init = 1'b1;
      dma_read_req = 1'b0;
      dma_write_req = 1'b0;
      RDMG = 1'b0;
      RSYNC = 1'b0;
      RRPLY = 1'b0;
      tick(3);
      checkOutput("reset_state", {dma_bus_master, dma_complete, dma_nxm, addr_drive, data_drive,
                                  TDMR, TDMGO, TSACK, TSYNC, TDIN, TDOUT}, 0);
      init = 1'b0;
      check_en = 1'b1;
      tick(2);

      $display("[TB] DATO transfer");
      applyStimulus(1'b1, 5, 10, 1'b0, lat);
      checkOutput("dato_latency_literal", lat, 3);
      tick(2);

      $display("[TB] DATI transfer");
      applyStimulus(1'b0, 2, 6, 1'b0, lat);
      checkOutput("dati_latency_literal", lat, 6);
      tick(2);

      $display("[TB] NXM timeout");
      n0 = n_nxm;
      applyStimulus(1'b1, 1, 0, 1'b1, lat);
      checkOutput("nxm_latency_literal", lat, 200);
      checkOutput("nxm_pulse_count", n_nxm - n0, 1);
      tick(2);

      $display("[TB] Grant passing");
      exp_write = 1'b0;
      RDMG = 1'b1;
      tick(4);
      checkOutput("tdmgo_on_grant", 32'(TDMGO), 1);
      dma_read_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         checkOutput("tdmgo_held", 32'(TDMGO), 1);
         checkOutput("no_dmr_while_passing", {TDMR, TSACK}, 0);
      end
      RDMG = 1'b0;
      t = cyc;
      waitSig(S_DMR, 1'b1, 10, "dmr_after_pass", t2);
      checkOutput("pass_to_dmr", t2 - t, 3);
      checkOutput("tdmgo_dropped", 32'(TDMGO), 0);
      dma_read_req = 1'b0;
      tick(1);
      checkOutput("dmr_drop_on_req_drop", {TDMR, TSACK}, 0);
      tick(3);

      $display("[TB] Reset mid-transfer");
      exp_write = 1'b1;
      dma_write_req = 1'b1;
      waitSig(S_DMR, 1'b1, 10, "rst_dmr", t);
      RDMG = 1'b1;
      waitSig(S_SACK, 1'b1, 10, "rst_sack", t);
      RDMG = 1'b0;
      waitSig(S_DOUT, 1'b1, 20, "rst_tdout", t);
      tick(10);
      c0 = n_done;
      n0 = n_nxm;
      init = 1'b1;
      tick(1);
      checkOutput("reset_mid_wait", {dma_bus_master, addr_drive, data_drive, TDMR, TSACK, TSYNC, TDOUT}, 0);
      init = 1'b0;
      dma_write_req = 1'b0;
      tick(5);
      checkOutput("no_pulse_after_reset", (n_done - c0) + (n_nxm - n0), 0);
      applyStimulus(1'b1, 3, 4, 1'b0, lat);
      checkOutput("post_reset_latency_literal", lat, 3);
      tick(2);

      $display("[TB] Six words with write_req held");
      exp_write = 1'b1;
      words = 0;
      periods = 0;
      cur = 0;
      prev_m = 1'b0;
      dma_write_req = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (TDMR) RDMG = 1'b1;
         if (TSACK) RDMG = 1'b0;
         RRPLY = TDOUT;
         if (dma_complete) begin
            words++;
            cur++;
            if (words == 6) dma_write_req = 1'b0;
         end
         if (prev_m && !dma_bus_master) begin
            if (periods < 8) per[periods] = cur;
            periods++;
            cur = 0;
         end
         prev_m = dma_bus_master;
         if (words == 6 && !dma_bus_master) break;
      end
      RRPLY = 1'b0;
      RDMG = 1'b0;
      checkOutput("words_done", words, 6);
      checkOutput("mastership_periods", periods, EXP_PERIODS);
      for (int i = 0; i < EXP_PERIODS && i < periods; i++)
         checkOutput("words_per_period", per[i], exp_per[i]);
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
